// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: function codes, ALU op encodings, FSM states and ALU control bundle
package alu_op_sequencer_pkg;
    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_SUB  = 4'd1;
    localparam logic [3:0] F_XOR  = 4'd2;
    localparam logic [3:0] F_ANDN = 4'd3;
    localparam logic [3:0] F_ROL  = 4'd4;
    localparam logic [3:0] F_SLL  = 4'd5;
    localparam logic [3:0] F_ROR  = 4'd6;
    localparam logic [3:0] F_SRL  = 4'd7;
    localparam logic [3:0] F_SEQ  = 4'd8;
    localparam logic [3:0] F_SLT  = 4'd9;
    localparam logic [3:0] F_SLE  = 4'd10;
    localparam logic [3:0] F_SCO  = 4'd11;
    localparam logic [3:0] F_BTR  = 4'd12;

    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_RESP} state_e;

    typedef struct packed {
        logic [2:0] op;
        logic       cin;
        logic       inva;
        logic       invb;
        logic       sign;
    } alu_ctl_t;

    function automatic logic [15:0] bit_rev(input logic [15:0] x);
        for (int i = 0; i < 16; i++) bit_rev[i] = x[15-i];
    endfunction
endpackage

// File: rtl/alu_op_sequencer_decode.sv
// alu_op_sequencer_decode: maps function code and pass number to ALU control lines
module alu_op_sequencer_decode
    import alu_op_sequencer_pkg::*;
#(
    parameter int FUNC_W = 4
) (
    input  logic [FUNC_W-1:0] func,
    input  logic              pass2,
    output alu_ctl_t          ctl
);
    always_comb begin
        ctl = '0;
        case (func)
            F_ADD:                      ctl = alu_ctl_t'{OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1};
            F_SUB:                      ctl = alu_ctl_t'{OP_ADD, 1'b1, 1'b1, 1'b0, 1'b1};
            F_XOR, F_SEQ:               ctl.op = OP_XOR;
            F_ANDN:                     ctl = alu_ctl_t'{OP_AND, 1'b0, 1'b0, 1'b1, 1'b0};
            F_ROL, F_SLL, F_ROR, F_SRL: ctl.op = {1'b0, func[1:0]};
            F_SLT:                      ctl = alu_ctl_t'{OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0};
            // SLE: equality via XOR first, then the Rt-Rs compare pass
            F_SLE:                      ctl = pass2 ? alu_ctl_t'{OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0}
                                                    : alu_ctl_t'{OP_XOR, 1'b0, 1'b0, 1'b0, 1'b0};
            F_SCO:                      ctl.op = OP_ADD;
            default:                    ;
        endcase
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: request/response sequencer driving an external combinational 16-bit ALU
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int FUNC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FUNC_W-1:0] req_func,
    input  logic [WIDTH-1:0]  req_a,
    input  logic [WIDTH-1:0]  req_b,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_cin,
    output logic              alu_inva,
    output logic              alu_invb,
    output logic              alu_sign,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_ofl,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_ofl,
    output logic              rsp_err
);
    state_e            state;
    logic [FUNC_W-1:0] func_r;
    logic [WIDTH-1:0]  a_r, b_r, res_data;
    logic              eq_r, in_pass, lt, set_op, res_bit, res_ofl;
    alu_ctl_t          ctl;

    alu_op_sequencer_decode #(.FUNC_W(FUNC_W)) u_decode (
        .func  (func_r),
        .pass2 (state == S_PASS2),
        .ctl   (ctl)
    );

    assign in_pass   = state == S_PASS1 || state == S_PASS2;
    assign req_ready = state == S_IDLE;
    assign alu_a     = in_pass ? a_r : '0;
    assign alu_b     = in_pass ? b_r : '0;
    assign alu_op    = in_pass ? ctl.op : '0;
    assign alu_cin   = in_pass & ctl.cin;
    assign alu_inva  = in_pass & ctl.inva;
    assign alu_invb  = in_pass & ctl.invb;
    assign alu_sign  = in_pass & ctl.sign;

    // Signed Rs < Rt from operand signs and the Rt-Rs difference on alu_out
    assign lt = (a_r[WIDTH-1] & ~b_r[WIDTH-1]) |
                (~(a_r[WIDTH-1] ^ b_r[WIDTH-1]) & ~alu_out[WIDTH-1] & |alu_out);

    assign set_op   = func_r == F_SEQ || func_r == F_SLT || func_r == F_SCO;
    assign res_bit  = func_r == F_SEQ ? alu_out == '0 : func_r == F_SLT ? lt : alu_cout;
    assign res_data = set_op ? {{(WIDTH-1){1'b0}}, res_bit} : alu_out;
    assign res_ofl  = (func_r == F_ADD || func_r == F_SUB) & alu_ofl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            func_r    <= '0;
            a_r       <= '0;
            b_r       <= '0;
            eq_r      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_ofl   <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    func_r <= req_func;
                    a_r    <= req_a;
                    b_r    <= req_b;
                    if (req_func >= F_BTR) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= req_func == F_BTR ? bit_rev(req_a) : '0;
                        rsp_ofl   <= 1'b0;
                        rsp_err   <= req_func != F_BTR;
                    end else begin
                        state <= S_PASS1;
                    end
                end
                S_PASS1: if (func_r == F_SLE) begin
                    eq_r  <= alu_out == '0;
                    state <= S_PASS2;
                end else begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= res_data;
                    rsp_ofl   <= res_ofl;
                    rsp_err   <= 1'b0;
                end
                S_PASS2: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= {{(WIDTH-1){1'b0}}, eq_r | lt};
                    rsp_ofl   <= 1'b0;
                    rsp_err   <= 1'b0;
                end
                S_RESP: if (rsp_ready) begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: sequencer plus behavioural ALU, checked by directed table, corner sequences and random traffic
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_ofl, rsp_err;
    logic [3:0]  req_func;
    logic [15:0] req_a, req_b, alu_a, alu_b, alu_out, rsp_data;
    logic [2:0]  alu_op;
    logic        alu_cin, alu_inva, alu_invb, alu_sign, alu_ofl, alu_cout;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_inva(alu_inva), .alu_invb(alu_invb), .alu_sign(alu_sign),
        .alu_out(alu_out), .alu_ofl(alu_ofl), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_ofl(rsp_ofl), .rsp_err(rsp_err)
    );

    // Stand-in combinational ALU
    logic [15:0] ax, bx;
    logic [16:0] sum;
    int          ssum, xi, sh;
    always_comb begin
        ax       = alu_inva ? ~alu_a : alu_a;
        bx       = alu_invb ? ~alu_b : alu_b;
        sum      = {1'b0, ax} + {1'b0, bx} + {16'b0, alu_cin};
        ssum     = int'($signed(ax)) + int'($signed(bx)) + int'(alu_cin);
        xi       = {16'b0, ax};
        sh       = {28'b0, bx[3:0]};
        alu_cout = sum[16];
        alu_ofl  = alu_sign ? (ssum > 32767 || ssum < -32768) : sum[16];
        alu_out  = sum[15:0];
        case (alu_op)
            3'b000:  alu_out = 16'((xi << sh) | (xi >> (16 - sh)));
            3'b001:  alu_out = 16'(xi << sh);
            3'b010:  alu_out = 16'((xi >> sh) | (xi << (16 - sh)));
            3'b011:  alu_out = 16'(xi >> sh);
            3'b110:  alu_out = ax ^ bx;
            3'b111:  alu_out = ax & bx;
            default: alu_out = sum[15:0];
        endcase
    end

    // Reference: what each function means, independent of how it is sequenced
    function automatic void refm(input logic [3:0] f, input logic [15:0] a, b,
                                 output logic [15:0] d, output logic o, e);
        int sa, sb, ua, ub, n, s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = {16'b0, a};
        ub = {16'b0, b};
        n  = ub & 15;
        d  = '0;
        o  = 1'b0;
        e  = 1'b0;
        case (f)
            4'd0:  begin s = sa + sb; d = 16'(ua + ub); o = s > 32767 || s < -32768; end
            4'd1:  begin s = sb - sa; d = 16'(ub - ua); o = s > 32767 || s < -32768; end
            4'd2:  d = a ^ b;
            4'd3:  d = a & ~b;
            4'd4:  d = 16'((ua << n) | (ua >> (16 - n)));
            4'd5:  d = 16'(ua << n);
            4'd6:  d = 16'((ua >> n) | (ua << (16 - n)));
            4'd7:  d = 16'(ua >> n);
            4'd8:  d = {15'b0, a == b};
            4'd9:  d = {15'b0, sa < sb};
            4'd10: d = {15'b0, sa <= sb};
            4'd11: d = {15'b0, (ua + ub) > 65535};
            4'd12: for (int i = 0; i < 16; i++) d[i] = a[15-i];
            default: e = 1'b1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction; lat counts edges from the accept edge until rsp_valid is seen
    task automatic txn(input logic [3:0] f, input logic [15:0] a, b, input int hold,
                       output logic [15:0] d, output logic o, e, output int lat);
        int w;
        req_func  = f;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        repeat (hold) begin @(posedge clk); #1; end
        d = rsp_data;
        o = rsp_ofl;
        e = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  f;
        logic [15:0] a, b, d;
        logic        o, e;
        int          lat;
    } vec_t;
    vec_t vecs[16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] d, ed, ra, rb;
        logic        o, e, eo, ee, seen;
        logic [3:0]  rf;
        int          lat, elat;
        vecs = '{
            '{4'd1,  16'h0003, 16'h0010, 16'h000D, 1'b0, 1'b0, 2},
            '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 2},
            '{4'd0,  16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 2},
            '{4'd1,  16'h8000, 16'h0001, 16'h8001, 1'b1, 1'b0, 2},
            '{4'd11, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 2},
            '{4'd10, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0, 3},
            '{4'd10, 16'h0005, 16'h0005, 16'h0001, 1'b0, 1'b0, 3},
            '{4'd10, 16'h0006, 16'h0005, 16'h0000, 1'b0, 1'b0, 3},
            '{4'd12, 16'h0001, 16'h0000, 16'h8000, 1'b0, 1'b0, 1},
            '{4'd14, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1},
            '{4'd2,  16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0, 2},
            '{4'd3,  16'hFFFF, 16'h00FF, 16'hFF00, 1'b0, 1'b0, 2},
            '{4'd7,  16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 2},
            '{4'd6,  16'h0001, 16'h0001, 16'h8000, 1'b0, 1'b0, 2},
            '{4'd9,  16'h0005, 16'h8000, 16'h0000, 1'b0, 1'b0, 2},
            '{4'd8,  16'h1234, 16'h1234, 16'h0001, 1'b0, 1'b0, 2}
        };
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_func = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", req_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_data", {rsp_data, rsp_ofl, rsp_err}, 0);
        chk("reset alu drive", {alu_a, alu_b, alu_op, alu_cin, alu_inva, alu_invb, alu_sign}, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            txn(vecs[i].f, vecs[i].a, vecs[i].b, 0, d, o, e, lat);
            chk($sformatf("vec%0d data", i), d, vecs[i].d);
            chk($sformatf("vec%0d ofl", i), o, vecs[i].o);
            chk($sformatf("vec%0d err", i), e, vecs[i].e);
            chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d idle after handshake", i), {req_ready, rsp_valid, alu_op}, 5'b10000);
        end

        // Response backpressure: ROL 0x8001 by 1 held for 5 cycles, new request ignored meanwhile
        req_func = 4'd4; req_a = 16'h8001; req_b = 16'h0001; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        req_func = 4'd12; req_a = 16'h0001; req_b = 16'h0000; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hold%0d rsp_valid", c), rsp_valid, 1);
            chk($sformatf("hold%0d rsp_data", c), rsp_data, 16'h0003);
            chk($sformatf("hold%0d req_ready", c), req_ready, 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("post-hold idle", {req_ready, rsp_valid}, 2'b10);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("queued BTR valid", rsp_valid, 1);
        chk("queued BTR data", rsp_data, 16'h8000);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset landing in the second pass of SLE
        req_func = 4'd10; req_a = 16'h8000; req_b = 16'h0001; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("sle pass1 op", {alu_op, alu_inva, alu_cin}, 5'b11000);
        @(posedge clk); #1;
        chk("sle pass2 op", {alu_op, alu_inva, alu_cin}, 5'b10011);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst-in-pass2 req_ready", req_ready, 1);
        chk("rst-in-pass2 alu idle", alu_op, 0);
        seen = rsp_valid;
        repeat (4) begin @(posedge clk); #1; seen |= rsp_valid; end
        chk("rst-in-pass2 no response", seen, 0);

        // Random traffic against the reference
        for (int t = 0; t < 200; t++) begin
            rf = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = ra;
                1:       rb = 16'h8000;
                2:       rb = 16'h7FFF;
                default: rb = 16'($urandom);
            endcase
            refm(rf, ra, rb, ed, eo, ee);
            elat = rf >= 4'd12 ? 1 : rf == 4'd10 ? 3 : 2;
            txn(rf, ra, rb, $urandom_range(0, 2), d, o, e, lat);
            chk($sformatf("rnd%0d f=%0d a=%h b=%h data", t, rf, ra, rb), d, ed);
            chk($sformatf("rnd%0d ofl", t), o, eo);
            chk($sformatf("rnd%0d err", t), e, ee);
            chk($sformatf("rnd%0d latency", t), lat, elat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
